// File: rtl/skinny_round_ctrl.sv
// Round sequencer for a SKINNY-128 datapath: issues load/enable strobes, LFSR round constant,
// round index and last-round flag, then holds the result behind a valid/ready handshake.
module skinny_round_ctrl #(
  parameter int NUM_ROUNDS   = 40,
  parameter int ROUND_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       in_ready,
  input  logic       abort,
  output logic       ld,
  output logic       en,
  output logic [5:0] rc,
  output logic [5:0] round,
  output logic       last_round,
  output logic       out_valid,
  input  logic       out_ready
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_e;

  localparam logic [5:0] LAST_ROUND = 6'(NUM_ROUNDS - 1);
  localparam logic [2:0] LAST_SUB   = 3'(ROUND_CYCLES - 1);

  state_e     state_q, state_d;
  logic [5:0] round_q, round_d;
  logic [5:0] rc_q, rc_d;
  logic [2:0] sub_q, sub_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      round_q <= 6'd0;
      rc_q    <= 6'h00;
      sub_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      rc_q    <= rc_d;
      sub_q   <= sub_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    round_d    = round_q;
    rc_d       = rc_q;
    sub_d      = sub_q;
    in_ready   = 1'b0;
    ld         = 1'b0;
    en         = 1'b0;
    out_valid  = 1'b0;
    last_round = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        // ld is a combinational mux select, so it must also be suppressed while rst is held
        if (start && !abort && !rst) begin
          ld      = 1'b1;
          state_d = ROUND;
          round_d = 6'd0;
          rc_d    = 6'h01;
          sub_d   = 3'd0;
        end
      end
      ROUND: begin
        last_round = (round_q == LAST_ROUND);
        if (abort) begin
          state_d = IDLE;
          round_d = 6'd0;
          rc_d    = 6'h00;
          sub_d   = 3'd0;
        end else if (sub_q == LAST_SUB) begin
          en    = 1'b1;
          sub_d = 3'd0;
          if (round_q == LAST_ROUND) begin
            state_d = DONE;
          end else begin
            round_d = round_q + 6'd1;
            rc_d    = {rc_q[4:0], rc_q[5] ^ rc_q[4] ^ 1'b1};
          end
        end else begin
          sub_d = sub_q + 3'd1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (abort || out_ready) begin
          state_d = IDLE;
          round_d = 6'd0;
          rc_d    = 6'h00;
          sub_d   = 3'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rc    = rc_q;
  assign round = round_q;

endmodule

// File: tb/tb_skinny_round_ctrl.sv
// Bench for skinny_round_ctrl: default instance (40 rounds x 1 cycle) and a 4 x 3 instance
// sharing stimulus, checked each cycle against a cycles-since-start model plus directed literals.
module tb_skinny_round_ctrl;

  logic clk = 1'b0;
  logic rst, start, abort, out_ready;

  logic       in_ready_a, ld_a, en_a, last_a, ov_a;
  logic [5:0] rc_a, round_a;
  logic       in_ready_b, ld_b, en_b, last_b, ov_b;
  logic [5:0] rc_b, round_b;

  skinny_round_ctrl dut_a (
    .clk(clk), .rst(rst), .start(start), .in_ready(in_ready_a), .abort(abort),
    .ld(ld_a), .en(en_a), .rc(rc_a), .round(round_a), .last_round(last_a),
    .out_valid(ov_a), .out_ready(out_ready)
  );

  skinny_round_ctrl #(.NUM_ROUNDS(4), .ROUND_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst), .start(start), .in_ready(in_ready_b), .abort(abort),
    .ld(ld_b), .en(en_b), .rc(rc_b), .round(round_b), .last_round(last_b),
    .out_valid(ov_b), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // {in_ready, ld, en, last_round, out_valid, rc, round}
  logic [16:0] act_a, act_b;
  assign act_a = {in_ready_a, ld_a, en_a, last_a, ov_a, rc_a, round_a};
  assign act_b = {in_ready_b, ld_b, en_b, last_b, ov_b, rc_b, round_b};

  function automatic logic [5:0] rc_of(input int r);
    logic [5:0] x;
    x = 6'h01;
    for (int i = 0; i < r; i++) x = {x[4:0], x[5] ^ x[4] ^ 1'b1};
    return x;
  endfunction

  // t = 0 means idle; otherwise the number of cycles since the start was accepted
  function automatic logic [16:0] exp_out(input int t, input int n, input int rcy,
                                          input logic s, input logic a, input logic r);
    int rn;
    if (r || t == 0) return {1'b1, s & ~a & ~r, 3'b000, 12'h000};
    if (t > n * rcy) begin
      rn = n - 1;
      return {5'b00001, rc_of(rn), 6'(rn)};
    end
    rn = (t - 1) / rcy;
    return {1'b0, 1'b0, ((t % rcy) == 0) && !a, rn == n - 1, 1'b0, rc_of(rn), 6'(rn)};
  endfunction

  int mt [2] = '{0, 0};
  int mn [2] = '{40, 4};
  int mr [2] = '{1, 3};

  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (rst)                  mt[d] = 0;
      else if (mt[d] == 0)      mt[d] = (start && !abort) ? 1 : 0;
      else if (abort)           mt[d] = 0;
      else if (mt[d] > mn[d] * mr[d]) begin
        if (out_ready) mt[d] = 0;
      end else                  mt[d] = mt[d] + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  int enA_total = 0, ovA_total = 0, lastA_total = 0, lastA_cyc = -1, ovA_rise = -1;
  int ovB_rise = -1;
  int enB_q [$];
  bit stim_done = 0;
  int c0;

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    c0 = cyc;
    #1;
    check("ld_on_start", ld_a, 1'b1);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_round_a(input int val);
    int k;
    k = 0;
    while ((round_a != 6'(val) || in_ready_a) && k < 80) begin
      @(posedge clk); #1;
      k++;
    end
    check("wait_round_timeout", k < 80, 1'b1);
  endtask

  initial begin
    int en0, ov0, last0, szb, k;
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    fork
      begin : monitor
        logic pa, pb;
        pa = 1'b0; pb = 1'b0;
        while (!stim_done) begin
          @(negedge clk);
          check("outA", act_a, exp_out(mt[0], mn[0], mr[0], start, abort, rst));
          check("outB", act_b, exp_out(mt[1], mn[1], mr[1], start, abort, rst));
          if (en_a) enA_total++;
          if (ov_a) ovA_total++;
          if (last_a) begin lastA_total++; lastA_cyc = cyc; end
          if (ov_a && !pa) ovA_rise = cyc;
          if (en_b) enB_q.push_back(cyc);
          if (ov_b && !pb) ovB_rise = cyc;
          pa = ov_a; pb = ov_b;
        end
      end
      begin : stimulus
        check("pin_rc0", rc_of(0), 6'h01);
        check("pin_rc24", rc_of(24), 6'h21);
        check("pin_rc39", rc_of(39), 6'h1A);
        check("pin_done", exp_out(41, 40, 1, 1'b0, 1'b0, 1'b0), {5'b00001, 6'h1A, 6'd39});
        #2;
        check("reset_a", act_a, 17'h10000);
        check("reset_b", act_b, 17'h10000);
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        // basic run, both instances
        en0 = enA_total; ov0 = ovA_total; last0 = lastA_total; szb = enB_q.size();
        pulse_start();
        repeat (44) @(posedge clk);
        #1;
        check("basic_en_count", enA_total - en0, 40);
        check("basic_last_count", lastA_total - last0, 1);
        check("basic_last_cycle", lastA_cyc - c0, 40);
        check("basic_ov_cycle", ovA_rise - c0, 41);
        check("basic_ov_count", ovA_total - ov0, 1);
        check("b_en_count", enB_q.size() - szb, 4);
        for (int i = 0; i < 4; i++)
          check("b_en_cycle", (szb + i < enB_q.size()) ? enB_q[szb + i] - c0 : -1, 3 * (i + 1));
        check("b_ov_cycle", ovB_rise - c0, 13);

        // backpressure with ignored start pulses
        out_ready = 1'b0;
        en0 = enA_total;
        pulse_start();
        k = 0;
        while (!ov_a && k < 80) begin @(posedge clk); #1; k++; end
        check("wait_ov_timeout", k < 80, 1'b1);
        for (int i = 0; i < 10; i++) begin
          @(posedge clk); #1;
          start = (i % 2 == 0);
        end
        start = 1'b0;
        check("bp_ov", ov_a, 1'b1);
        check("bp_round", round_a, 6'd39);
        check("bp_rc", rc_a, 6'h1A);
        check("bp_en_count", enA_total - en0, 40);
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("bp_in_ready", in_ready_a, 1'b1);

        // abort in round 17, then a full rerun
        ov0 = ovA_total;
        pulse_start();
        wait_round_a(17);
        check("r17_rc", rc_a, 6'h3A);
        abort = 1'b1;
        #1 check("abort_no_en", en_a, 1'b0);
        @(posedge clk); #1 abort = 1'b0;
        check("abort_idle", in_ready_a, 1'b1);
        check("abort_rc", rc_a, 6'h00);
        check("abort_round", round_a, 6'd0);
        repeat (5) @(posedge clk);
        check("abort_no_ov", ovA_total - ov0, 0);
        en0 = enA_total;
        pulse_start();
        repeat (44) @(posedge clk);
        #1;
        check("rerun_en_count", enA_total - en0, 40);
        check("rerun_ov_cycle", ovA_rise - c0, 41);

        // async reset mid-cycle in round 5
        pulse_start();
        wait_round_a(5);
        check("r5_rc", rc_a, 6'h3E);
        @(negedge clk); #1 rst = 1'b1;
        #1;
        check("async_rst_a", act_a, 17'h10000);
        check("async_rst_b", act_b, 17'h10000);
        #1 rst = 1'b0;
        en0 = enA_total;
        repeat (5) @(posedge clk);
        #1;
        check("rst_no_en", enA_total - en0, 0);
        check("rst_in_ready", in_ready_a, 1'b1);

        // start and abort together in IDLE
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1;
        #1;
        check("sa_ld_a", ld_a, 1'b0);
        check("sa_ld_b", ld_b, 1'b0);
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        check("sa_idle", in_ready_a, 1'b1);
        repeat (3) @(posedge clk);
        stim_done = 1;
      end
    join
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/skinny_round_ctrl.md
Name: skinny_round_ctrl

Overview:
- Round sequencer for the SKINNY-128 round datapath used by the Romulus accelerator.
- Per round, the datapath applies the 16-byte S-box layer, AddConstant, ShiftRows and MixColumns to a 128-bit state register.
- This block accepts a start handshake and produces the datapath control: state-register load and enable, the 6-bit LFSR round constant, round index and last-round flag.
- After the final round it presents the result through a valid/ready handshake. The block contains no 128-bit datapath of its own.

Parameters:
- NUM_ROUNDS, 40, rounds per block encryption (SKINNY-128-384+); legal range 1..63.
- ROUND_CYCLES, 1, clock cycles per round, to support multi-cycle or serialized datapaths; legal range 1..8.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request to encrypt the state presented on the datapath input.
- in_ready  output  1  high in IDLE; start is accepted when start & in_ready.
- abort  input  1  synchronous cancel; returns to IDLE.
- ld  output  1  datapath mux select: load input into the state register (combinational).
- en  output  1  state-register enable: commit one round result (combinational).
- rc  output  6  current round constant.
- round  output  6  current round index, 0..NUM_ROUNDS-1.
- last_round  output  1  high throughout the final round.
- out_valid  output  1  result valid in the state register.
- out_ready  input  1  consumer accepts the result.

Behaviour:
- Reset: asynchronous on rst.
  - State = IDLE, round = 0, rc = 0x00, sub-cycle counter = 0.
  - in_ready = 1, out_valid = 0, ld = 0, en = 0, last_round = 0.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready = 1.
  - On start: ld = 1 in the same cycle, which loads the input into the state register.
  - Next state ROUND, with round = 0, rc = 0x01, sub = 0.
- ROUND:
  - sub counts 0..ROUND_CYCLES-1.
  - en = 1 only in the cycle where sub == ROUND_CYCLES-1.
  - On that cycle, if round < NUM_ROUNDS-1: round increments, rc advances one LFSR step, sub resets to 0.
  - If round == NUM_ROUNDS-1: next state DONE; rc and round hold their values.
- LFSR step: rc_next = {rc[4:0], rc[5] ^ rc[4] ^ 1}.
  - Sequence from 0x01: 01,03,07,0F,1F,3E,3D,3B,37,2F,1E,3C,39,33,27,0E,1D,3A,35,2B,16,2C,18,30,21,02,05,0B,17,2E,1C,38,31,23,06,0D,1B,36,2D,1A.
  - rc in round 39 = 0x1A.
- last_round = (state == ROUND) & (round == NUM_ROUNDS-1).
- DONE:
  - out_valid = 1, held until out_ready.
  - On out_ready: next state IDLE, out_valid drops, round and rc clear to 0.
  - start is ignored in DONE.
- Latency: start accepted in cycle 0.
  - en pulses in cycles k*ROUND_CYCLES for k = 1..NUM_ROUNDS.
  - out_valid first high in cycle NUM_ROUNDS*ROUND_CYCLES + 1. Defaults: cycle 41.
- Throughput: the earliest next start is the cycle after out_ready is accepted, because in_ready returns the cycle after the DONE-to-IDLE transition.
- abort:
  - In ROUND or DONE: next state IDLE, all counters clear, no en in that cycle, and no out_valid for the aborted job.
  - In IDLE: abort has priority over start. start is not accepted and ld = 0.
- Reset mid-round forces the reset values immediately, with no further en or out_valid. After rst deasserts, the block waits for a new start.
- ld and en are never high in the same cycle.
- out_valid and in_ready are never high together.

Test Plan:
- Basic run, defaults:
  - Stimulus: start=1 for one cycle, out_ready=1.
  - Required: ld=1 in cycle 0; exactly 40 en pulses in cycles 1..40; rc sequence 01..1A as listed; last_round high only in cycle 40; out_valid high in cycle 41 only; in_ready=1 in cycle 42.
- Backpressure:
  - Stimulus: out_ready=0 for 10 cycles after out_valid rises.
  - Required: out_valid, round=39 and rc=0x1A stay stable for 10 cycles; no en pulses; start pulses during that window are ignored.
- ROUND_CYCLES=3, NUM_ROUNDS=4:
  - Stimulus: one start.
  - Required: en in cycles 3, 6, 9, 12; rc 01, 03, 07, 0F; out_valid in cycle 13.
- Abort:
  - Stimulus: abort in round 17.
  - Required: IDLE next cycle; rc=0, round=0; no en in the abort cycle; out_valid never rises; a following start runs all 40 rounds from rc=0x01.
- Async reset:
  - Stimulus: rst pulsed between clock edges in round 5.
  - Required: all outputs take their reset values immediately, without waiting for a clock edge; no en afterwards.
- Simultaneous start and abort in IDLE:
  - Required: not accepted, ld=0, state stays IDLE.
